// File: rtl/ps2_kbd_seg_display.sv
// rtl/ps2_kbd_seg_display.sv - PS/2 keyboard receiver, FIFO, make/break decoder and six-digit hex display.
// Optional feature macro: PS2_PARITY_CHECK_EN (full start/stop/odd-parity frame check).
module ps2_kbd_seg_display #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4,
  output logic [6:0] seg5,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Receiver state
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [8:0]             shift_q, shift_d;
  logic                   frame_vld_q, frame_vld_d;
  logic [7:0]             frame_byte_q, frame_byte_d;
  logic                   ps2_fall;
  logic                   frame_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic                   parity_q, parity_d;
`endif

  // FIFO state
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [7:0]  fifo_rdata;

  // Decoder state
  logic [7:0] key_q, key_d;
  logic       pressing_q, pressing_d;
  logic       break_pending_q, break_pending_d;
  logic [7:0] count_q, count_d;
  logic [7:0] ascii;

  assign ps2_fall = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], ps2_clk};
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    frame_vld_d  = 1'b0;
    frame_byte_d = frame_byte_q;
`ifdef PS2_PARITY_CHECK_EN
    parity_d     = parity_q;
    frame_ok     = ~shift_q[0] & ps2_data & (^{shift_q[8:1], parity_q});
`else
    frame_ok     = ~shift_q[0];
`endif
    if (ps2_fall) begin
      if (bit_cnt_q == 4'd10) begin
        // ps2_data here is the stop bit of the completing frame
        bit_cnt_d    = 4'd0;
        frame_vld_d  = frame_ok;
        frame_byte_d = shift_q[8:1];
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q < 4'd9) begin
          shift_d = {ps2_data, shift_q[8:1]};
        end
`ifdef PS2_PARITY_CHECK_EN
        if (bit_cnt_q == 4'd9) begin
          parity_d = ps2_data;
        end
`endif
      end
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_push  = frame_vld_q & ~fifo_full;
  assign fifo_pop   = ~fifo_empty;
  assign fifo_rdata = fifo_mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (frame_vld_q && fifo_full) begin
      overflow_d = 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= frame_byte_q;
    end
  end

  // Make/break tracking; E0 prefixes are dropped so extended keys decode as their base code
  always_comb begin
    key_d           = key_q;
    pressing_d      = pressing_q;
    break_pending_d = break_pending_q;
    count_d         = count_q;
    if (fifo_pop) begin
      if (fifo_rdata == 8'hF0) begin
        break_pending_d = 1'b1;
      end else if (fifo_rdata == 8'hE0) begin
        break_pending_d = break_pending_q;
      end else if (break_pending_q) begin
        break_pending_d = 1'b0;
        if (fifo_rdata == key_q) begin
          pressing_d = 1'b0;
        end
      end else if (!pressing_q || fifo_rdata != key_q) begin
        pressing_d = 1'b1;
        key_d      = fifo_rdata;
        count_d    = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      sync_q          <= '1;
      bit_cnt_q       <= 4'd0;
      shift_q         <= '0;
      frame_vld_q     <= 1'b0;
      frame_byte_q    <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
      parity_q        <= 1'b0;
`endif
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      overflow_q      <= 1'b0;
      key_q           <= 8'h00;
      pressing_q      <= 1'b0;
      break_pending_q <= 1'b0;
      count_q         <= 8'h00;
    end else begin
      sync_q          <= sync_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      frame_vld_q     <= frame_vld_d;
      frame_byte_q    <= frame_byte_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q        <= parity_d;
`endif
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      overflow_q      <= overflow_d;
      key_q           <= key_d;
      pressing_q      <= pressing_d;
      break_pending_q <= break_pending_d;
      count_q         <= count_d;
    end
  end

  // Scan code set 2 to ASCII
  always_comb begin
    case (key_q)
      8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;
      default: ascii = 8'h00;
    endcase
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign seg0     = pressing_q ? hex7(key_q[3:0]) : 7'h7F;
  assign seg1     = pressing_q ? hex7(key_q[7:4]) : 7'h7F;
  assign seg2     = pressing_q ? hex7(ascii[3:0]) : 7'h7F;
  assign seg3     = pressing_q ? hex7(ascii[7:4]) : 7'h7F;
  assign seg4     = hex7(count_q[3:0]);
  assign seg5     = hex7(count_q[7:4]);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_seg_display.sv
// tb/tb_ps2_kbd_seg_display.sv - directed bench for ps2_kbd_seg_display.
module tb_ps2_kbd_seg_display;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [6:0] seg0, seg1, seg2, seg3, seg4, seg5;
  logic       overflow;
  int         tests = 0;
  int         fails = 0;

  ps2_kbd_seg_display #(.FIFO_DEPTH(8), .SYNC_STAGES(3)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5),
    .overflow(overflow)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_parity);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) clrn = 1'b1;
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3,
                         input logic [6:0] e4, input logic [6:0] e5);
    chk({tag, "_seg0"}, seg0, e0);
    chk({tag, "_seg1"}, seg1, e1);
    chk({tag, "_seg2"}, seg2, e2);
    chk({tag, "_seg3"}, seg3, e3);
    chk({tag, "_seg4"}, seg4, e4);
    chk({tag, "_seg5"}, seg5, e5);
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    repeat (10) @(negedge clk);
    chk_all("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40);
    chk("reset_ovf", {6'd0, overflow}, 7'd0);

    // Press 'a' (1C): key 1C, ascii 61, count 01
    send_frame(8'h1C, 1'b0);
    chk_all("press_1c", 7'h46, 7'h79, 7'h79, 7'h02, 7'h79, 7'h40);

    // Typematic repeats do not count
    for (int i = 0; i < 5; i++) send_frame(8'h1C, 1'b0);
    chk_all("repeat_1c", 7'h46, 7'h79, 7'h79, 7'h02, 7'h79, 7'h40);

    // Release blanks key/ascii, count retained
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk_all("release_1c", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40);

    // Rollover: 1C then 32 without release
    do_reset();
    send_frame(8'h1C, 1'b0);
    send_frame(8'h32, 1'b0);
    chk_all("roll_32", 7'h24, 7'h30, 7'h24, 7'h02, 7'h24, 7'h40);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk_all("stale_break", 7'h24, 7'h30, 7'h24, 7'h02, 7'h24, 7'h40);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h32, 1'b0);
    chk_all("release_32", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40);

    // Frame with wrong parity
    send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    chk_all("bad_parity", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40);
`else
    chk_all("bad_parity", 7'h46, 7'h79, 7'h79, 7'h02, 7'h30, 7'h40);
`endif
    chk("bad_parity_ovf", {6'd0, overflow}, 7'd0);

    // Reset in the middle of a frame, then a clean frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    do_reset();
    send_frame(8'h1C, 1'b0);
    chk_all("midreset_1c", 7'h46, 7'h79, 7'h79, 7'h02, 7'h79, 7'h40);

    // Counter wrap with key '0' (45)
    do_reset();
    for (int i = 0; i < 255; i++) begin
      send_frame(8'h45, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h45, 1'b0);
    end
    chk("cnt_ff_seg4", seg4, 7'h0E);
    chk("cnt_ff_seg5", seg5, 7'h0E);
    send_frame(8'h45, 1'b0);
    chk_all("press_45", 7'h12, 7'h19, 7'h40, 7'h30, 7'h40, 7'h40);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h45, 1'b0);
    chk_all("wrap_00", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40);
    chk("final_ovf", {6'd0, overflow}, 7'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_seg_display.md
Name: ps2_kbd_seg_display

Overview:
Complete PS/2 keyboard front end driving six 7-segment digits. It receives PS/2 frames, buffers the bytes in a FIFO and filters break sequences. It tracks the currently pressed key and counts key presses. It displays the scan code, the mapped ASCII code and the press count in hex. It sits between the board PS/2 connector and the HEX displays, and merges the receiver, scan-to-ASCII lookup and display-decode functions into one block.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries (power of 2).
SYNC_STAGES, 3, ps2_clk synchronizer flops (at least 2).

Ports:
clk  in  1  system clock, 50 MHz nominal; all state on the rising edge.
clrn  in  1  reset, asynchronous, active-high (the name is kept for consistency with the codebase).
ps2_clk  in  1  raw PS/2 clock from the device.
ps2_data  in  1  raw PS/2 data from the device.
seg0..seg5  out  7 each  active-low segments {g,f,e,d,c,b,a}. seg1:seg0 show the scan code, seg3:seg2 the ASCII code, seg5:seg4 the press counter (high:low nibble).
overflow  out  1  sticky flag: a frame arrived while the FIFO was full.

Behaviour:
- Reset (clrn=1, async): synchronizer=1s, bit count=0, FIFO empty, overflow=0, key=00, pressing=0, break_pending=0, counter=00. Resulting outputs: seg0..seg3=7'h7F (blank), seg4=seg5=7'h40 ("0").
- Receiver: ps2_clk passes through SYNC_STAGES flops. A falling edge is the registered 1 followed by 0; ps2_data is sampled on that edge.
- Frame format: 11 bits, LSB first: start(0), d0..d7, parity, stop(1). A frame is complete on the 11th sample, and the bit count then returns to 0.
- Frame check: valid if start=0, stop=1 and d0..d7 plus parity have odd parity.
- Valid bytes are pushed into the FIFO on the cycle after completion. If the FIFO is full the byte is dropped and overflow is set; overflow clears only on reset.
- Reset mid-frame discards the partial frame.
- Decoder pop rule: pops one byte per cycle whenever the FIFO is non-empty, and updates its registers on that same edge.
- Decoder, byte F0: set break_pending; no other change.
- Decoder, byte E0: ignored (extended prefix).
- Decoder, byte with break_pending=1: clear break_pending. If the byte equals key, set pressing=0 (key is retained). Otherwise no change.
- Decoder, make byte with pressing=0: pressing=1, key=byte, counter+1.
- Decoder, make byte equal to key with pressing=1: typematic repeat; no change.
- Decoder, make byte different from key with pressing=1: key=byte, counter+1.
- Counter: 8 bits, wraps FF to 00.
- ASCII lookup (scan set 2, combinational on key):
  - letters, lowercase: 1C a(61), 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z(7A).
  - digits: 45 0(30), 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9.
  - others: 29 space(20), 5A enter(0D); every other code gives 00.
- Hex-to-7-segment, active-low, {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Display: seg0..seg3 show key and ASCII when pressing=1, and are blank (7F) otherwise. seg4/seg5 always show the counter. All segment outputs are combinational from the registered state.
- Latency: the 11th falling-edge sample is registered at cycle N. The byte is in the FIFO at N+1, the decoder state updates at N+2, and the segments are valid at N+2.

Optional Feature:
Macro PS2_PARITY_CHECK_EN.
- Defined: frames failing the start, stop or odd-parity check are discarded silently (not pushed, overflow unaffected).
- Undefined: only the start bit is checked; parity and stop are ignored, and d0..d7 is pushed.

Test Plan:
- Reset, then idle: seg0..3=7F, seg4=seg5=40, overflow=0.
- Frame 1C: seg1=79, seg0=46, seg3=02 (6), seg2=79 (1), seg4=79, seg5=40 (count 01).
- 1C repeated 5 times, then F0 1C: count stays 01 during the repeats. After the release seg0..3=7F and seg5:seg4 still read 01.
- Press 1C, then 32 without releasing: key shows 32 and ASCII shows 62, count 02. Then F0 1C: no change (pressing remains). Then F0 32: display blanks.
- 256 press/release pairs of 45: counter wraps to 00 (seg4=seg5=40).
- With PS2_PARITY_CHECK_EN defined, frame 1C with wrong parity: no display or counter change. Reset asserted mid-frame, then a valid 1C: decoded correctly.
